nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: RESET_L  in  1  synchronous reset, active-low, sampled on CLK rising edge.
REQ-003 SHALL have ports: NIB_IN  in  4  input nibble.
REQ-004 SHALL have ports: NIB_VALID  in  1  NIB_IN valid.
REQ-005 SHALL have ports: NIB_READY  out  1  packer accepts NIB_IN this cycle.
REQ-006 SHALL have ports: FLUSH  in  1  request to emit the partial word, zero-padded.
REQ-007 SHALL have ports: NIBBLES  out  16  packed word at the output-buffer head; feeds the downstream 4-nibble maximum selector.
REQ-008 SHALL have ports: NIBBLES_CNT  out  3  real nibbles in NIBBLES (1..4); 0 when empty.
REQ-009 SHALL have ports: NIBBLES_VALID  out  1  output-buffer head valid.
REQ-010 SHALL have ports: NIBBLES_READY  in  1  downstream consumes the head this cycle.

Function
REQ-011 Input transfer SHALL occur on a CLK edge with NIB_VALID=1 and NIB_READY=1; output transfer SHALL occur with NIBBLES_VALID=1 and NIBBLES_READY=1.
REQ-012 Packing order SHALL be: 1st nibble of a word to NIBBLES[3:0], 2nd to [7:4], 3rd to [11:8], 4th to [15:12].
REQ-013 A 2-bit fill counter SHALL track nibbles in the assembly register; states IDLE (0) and FILLING (1..3).
REQ-014 On the 4th accepted nibble, the completed word SHALL be pushed into the output buffer with CNT=4 in the same edge; the fill counter SHALL wrap to 0 (IDLE).
REQ-015 The output buffer SHALL be a 2-entry FIFO; NIBBLES_VALID SHALL assert the cycle after the push edge (latency 1 cycle from 4th accept).
REQ-016 NIBBLES and NIBBLES_CNT SHALL present the FIFO head when NIBBLES_VALID=1, and 16'h0000 and 0 when the FIFO is empty.
REQ-017 NIB_READY SHALL be 0 when (fill=3 and FIFO full) or flush_pending=1; otherwise 1. NIB_READY SHALL NOT depend combinationally on NIBBLES_READY.
REQ-018 Simultaneous push and pop SHALL be allowed when the FIFO is non-full; occupancy SHALL remain unchanged.
REQ-019 FLUSH with fill>0 (counting a nibble accepted in the same cycle) SHALL push the assembly word with unfilled nibbles = 0 and CNT = fill count, then reset fill to 0.
REQ-020 FLUSH when fill=0 and no nibble accepted SHALL be ignored.
REQ-021 FLUSH when a same-cycle accept completes a word (4th nibble) SHALL push only that full word; no extra empty word.
REQ-022 FLUSH that cannot push (FIFO full) SHALL set flush_pending; the push SHALL occur on the first edge the FIFO is not full, then flush_pending SHALL clear.
REQ-023 The FIFO SHALL never overflow; a pop with the FIFO empty SHALL have no effect.

Reset
REQ-024 With RESET_L=0 at an edge: fill=0, FIFO empty, flush_pending=0, NIBBLES=16'h0000, NIBBLES_CNT=0, NIBBLES_VALID=0.
REQ-025 During reset cycles, NIB_READY SHALL be 0; it SHALL return to 1 on the first cycle after RESET_L=1.
REQ-026 Reset mid-word or with the FIFO occupied SHALL discard all partial and buffered data; no stale word SHALL appear after release.

Verification
REQ-027 Scenario: NIB_IN=1,2,3,4 on consecutive cycles, NIBBLES_READY=1 -> NIBBLES=16'h4321, CNT=4, VALID=1 for one cycle, starting the cycle after the 4th accept.
REQ-028 Scenario: NIBBLES_READY=0; send 12 nibbles A,B,C,D,E,F,1,2,3,4,5,6 -> words 16'hDCBA and 16'h21FE buffered; NIB_READY=0 after the 11th nibble (fill=3, full); the 12th nibble is held. Raise NIBBLES_READY -> 16'h6543 emitted third.
REQ-029 Scenario: nibbles 7,8, then FLUSH -> NIBBLES=16'h0087, CNT=2. FLUSH again at fill=0 -> no word.
REQ-030 Scenario: FLUSH with FIFO full and fill=1 (nibble 9) -> NIB_READY=0 until a pop; then 16'h0009, CNT=1 pushed and NIB_READY=1.
REQ-031 Scenario: RESET_L=0 for 1 cycle at fill=2 with 1 buffered word -> VALID=0, NIBBLES=0; next 4 nibbles 5,6,7,8 -> 16'h8765.
REQ-032 Scenario: random NIB_VALID/NIBBLES_READY, 10k cycles -> scoreboard matches order, no loss, no duplication.

Source files
------------

// File: rtl/nibble_packer_if.sv
// rtl/nibble_packer_if.sv - nibble input stream and packed-word output stream bundle
interface nibble_packer_if;
  logic [3:0]  NIB_IN;
  logic        NIB_VALID;
  logic        NIB_READY;
  logic        FLUSH;
  logic [15:0] NIBBLES;
  logic [2:0]  NIBBLES_CNT;
  logic        NIBBLES_VALID;
  logic        NIBBLES_READY;

  modport master (
    output NIB_IN, NIB_VALID, FLUSH, NIBBLES_READY,
    input  NIB_READY, NIBBLES, NIBBLES_CNT, NIBBLES_VALID
  );

  modport slave (
    input  NIB_IN, NIB_VALID, FLUSH, NIBBLES_READY,
    output NIB_READY, NIBBLES, NIBBLES_CNT, NIBBLES_VALID
  );
endinterface

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs nibbles into 16-bit words through a 2-entry output FIFO
module nibble_packer (
  input  logic           CLK,
  input  logic           RESET_L,
  nibble_packer_if.slave bus
);
  logic [1:0]  r_fill;
  logic [15:0] r_asm;
  logic        r_flush_pend;
  logic [15:0] r_mem_word [2];
  logic [2:0]  r_mem_cnt  [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic [15:0] w_word;
  logic [2:0]  w_word_cnt;
  logic [1:0]  w_fill_nxt;
  logic [15:0] w_asm_nxt;
  logic        w_pend_nxt;

  assign w_full   = (r_count == 2'd2);
  assign w_empty  = (r_count == 2'd0);
  // Ready looks only at local state so upstream never waits on the downstream handshake.
  assign bus.NIB_READY = RESET_L && !((r_fill == 2'd3 && w_full) || r_flush_pend);
  assign w_accept = bus.NIB_VALID && bus.NIB_READY;
  assign w_pop    = bus.NIBBLES_READY && !w_empty;

  assign bus.NIBBLES_VALID = !w_empty;
  assign bus.NIBBLES       = w_empty ? 16'h0000 : r_mem_word[r_rptr];
  assign bus.NIBBLES_CNT   = w_empty ? 3'd0 : r_mem_cnt[r_rptr];

  always_comb begin
    w_word     = r_asm;
    w_word_cnt = {1'b0, r_fill};
    w_push     = 1'b0;
    w_fill_nxt = r_fill;
    w_asm_nxt  = r_asm;
    w_pend_nxt = r_flush_pend;
    if (w_accept) begin
      w_word     = r_asm | ({12'h000, bus.NIB_IN} << {r_fill, 2'b00});
      w_word_cnt = {1'b0, r_fill} + 3'd1;
    end
    // A completed word always has room: ready is low at fill=3 with a full FIFO.
    if (w_word_cnt == 3'd4) begin
      w_push     = 1'b1;
      w_fill_nxt = 2'd0;
      w_asm_nxt  = 16'h0000;
    end else if ((bus.FLUSH || r_flush_pend) && w_word_cnt != 3'd0) begin
      if (!w_full) begin
        w_push     = 1'b1;
        w_fill_nxt = 2'd0;
        w_asm_nxt  = 16'h0000;
        w_pend_nxt = 1'b0;
      end else begin
        w_pend_nxt = 1'b1;
        w_fill_nxt = w_word_cnt[1:0];
        w_asm_nxt  = w_word;
      end
    end else begin
      w_fill_nxt = w_word_cnt[1:0];
      w_asm_nxt  = w_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_fill       <= 2'd0;
      r_asm        <= 16'h0000;
      r_flush_pend <= 1'b0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_fill       <= w_fill_nxt;
      r_asm        <= w_asm_nxt;
      r_flush_pend <= w_pend_nxt;
      if (w_push) begin
        r_mem_word[r_wptr] <= w_word;
        r_mem_cnt[r_wptr]  <= w_word_cnt;
        r_wptr             <= !r_wptr;
      end
      if (w_pop) begin
        r_rptr <= !r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - scoreboard bench for nibble_packer
module tb_nibble_packer;
  logic clk = 1'b0;
  logic RESET_L;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0]  partial[$];
  logic [18:0] exp_q[$];

  nibble_packer_if bus();

  nibble_packer dut (
    .CLK     (clk),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    bus.NIB_IN    = n;
    bus.NIB_VALID = 1'b1;
    tick();
    bus.NIB_VALID = 1'b0;
  endtask

  task automatic emit_expected;
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < partial.size(); i++) w[4*i +: 4] = partial[i];
    exp_q.push_back({3'(partial.size()), w});
    partial.delete();
  endtask

  // Negedge view of the bus equals what the next rising edge will transfer.
  always @(negedge clk) begin
    logic [18:0] e;
    if (!RESET_L) begin
      partial.delete();
      exp_q.delete();
    end else begin
      if (bus.NIBBLES_VALID) begin
        check("cnt_range", 32'(bus.NIBBLES_CNT >= 3'd1 && bus.NIBBLES_CNT <= 3'd4), 32'd1);
      end else begin
        check("idle_word", 32'(bus.NIBBLES), 32'h0);
        check("idle_cnt", 32'(bus.NIBBLES_CNT), 32'h0);
      end
      if (bus.NIBBLES_VALID && bus.NIBBLES_READY) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {13'h0, bus.NIBBLES_CNT, bus.NIBBLES}, 32'h7ffff);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", 32'(bus.NIBBLES), 32'(e[15:0]));
          check("sb_cnt", 32'(bus.NIBBLES_CNT), 32'(e[18:16]));
        end
      end
      if (bus.NIB_VALID && bus.NIB_READY) partial.push_back(bus.NIB_IN);
      if (partial.size() == 4) emit_expected();
      else if (bus.FLUSH && partial.size() > 0) emit_expected();
    end
  end

  initial begin
    RESET_L           = 1'b0;
    bus.NIB_IN        = 4'h0;
    bus.NIB_VALID     = 1'b0;
    bus.FLUSH         = 1'b0;
    bus.NIBBLES_READY = 1'b0;
    tick(); tick(); tick();
    check("rst_ready", 32'(bus.NIB_READY), 32'd0);
    check("rst_valid", 32'(bus.NIBBLES_VALID), 32'd0);
    check("rst_word", 32'(bus.NIBBLES), 32'h0);
    check("rst_cnt", 32'(bus.NIBBLES_CNT), 32'h0);
    RESET_L = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.NIB_READY), 32'd1);

    // Four nibbles straight through
    bus.NIBBLES_READY = 1'b1;
    send(4'h1); send(4'h2); send(4'h3);
    check("s1_not_yet", 32'(bus.NIBBLES_VALID), 32'd0);
    send(4'h4);
    check("s1_valid", 32'(bus.NIBBLES_VALID), 32'd1);
    check("s1_word", 32'(bus.NIBBLES), 32'h4321);
    check("s1_cnt", 32'(bus.NIBBLES_CNT), 32'd4);
    tick();
    check("s1_one_cycle", 32'(bus.NIBBLES_VALID), 32'd0);

    // Backpressure: full FIFO at fill=3 holds the 12th nibble
    bus.NIBBLES_READY = 1'b0;
    begin
      logic [3:0] seq [12];
      seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      for (int i = 0; i < 11; i++) begin
        check("s2_ready_before", 32'(bus.NIB_READY), 32'd1);
        send(seq[i]);
      end
      check("s2_ready_full", 32'(bus.NIB_READY), 32'd0);
      bus.NIB_IN    = seq[11];
      bus.NIB_VALID = 1'b1;
      tick(); tick();
      check("s2_held", 32'(bus.NIB_READY), 32'd0);
      check("s2_head", 32'(bus.NIBBLES), 32'hDCBA);
      bus.NIBBLES_READY = 1'b1;
      tick();
      check("s2_ready_after_pop", 32'(bus.NIB_READY), 32'd1);
      check("s2_second", 32'(bus.NIBBLES), 32'h21FE);
      tick();
      bus.NIB_VALID = 1'b0;
      check("s2_third", 32'(bus.NIBBLES), 32'h6543);
      check("s2_third_cnt", 32'(bus.NIBBLES_CNT), 32'd4);
      tick();
      check("s2_drained", 32'(bus.NIBBLES_VALID), 32'd0);
    end

    // Partial flush, then flush at fill=0
    bus.NIBBLES_READY = 1'b0;
    send(4'h7); send(4'h8);
    bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0;
    check("s3_word", 32'(bus.NIBBLES), 32'h0087);
    check("s3_cnt", 32'(bus.NIBBLES_CNT), 32'd2);
    bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0;
    bus.NIBBLES_READY = 1'b1;
    tick();
    check("s3_no_empty_word", 32'(bus.NIBBLES_VALID), 32'd0);
    tick();
    check("s3_still_empty", 32'(bus.NIBBLES_VALID), 32'd0);

    // Flush coinciding with 4th nibble, and with a first nibble
    send(4'h1); send(4'h2); send(4'h3);
    bus.FLUSH = 1'b1; send(4'h4); bus.FLUSH = 1'b0;
    check("s4_word", 32'(bus.NIBBLES), 32'h4321);
    check("s4_cnt", 32'(bus.NIBBLES_CNT), 32'd4);
    tick();
    check("s4_single", 32'(bus.NIBBLES_VALID), 32'd0);
    bus.FLUSH = 1'b1; send(4'h5); bus.FLUSH = 1'b0;
    check("s4b_word", 32'(bus.NIBBLES), 32'h0005);
    check("s4b_cnt", 32'(bus.NIBBLES_CNT), 32'd1);
    tick();

    // Flush while FIFO full waits for a pop
    bus.NIBBLES_READY = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i));
    send(4'h9);
    bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0;
    check("s5_pend_ready", 32'(bus.NIB_READY), 32'd0);
    tick();
    check("s5_pend_hold", 32'(bus.NIB_READY), 32'd0);
    bus.NIBBLES_READY = 1'b1;
    tick();
    bus.NIBBLES_READY = 1'b0;
    check("s5_head2", 32'(bus.NIBBLES), 32'h8765);
    tick();
    check("s5_ready_back", 32'(bus.NIB_READY), 32'd1);
    bus.NIBBLES_READY = 1'b1;
    tick();
    check("s5_flush_word", 32'(bus.NIBBLES), 32'h0009);
    check("s5_flush_cnt", 32'(bus.NIBBLES_CNT), 32'd1);
    tick();
    check("s5_drained", 32'(bus.NIBBLES_VALID), 32'd0);

    // Reset with one buffered word and fill=2
    bus.NIBBLES_READY = 1'b0;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    send(4'hA); send(4'hB);
    RESET_L = 1'b0; tick(); RESET_L = 1'b1;
    check("s6_valid", 32'(bus.NIBBLES_VALID), 32'd0);
    check("s6_word", 32'(bus.NIBBLES), 32'h0);
    send(4'h5); send(4'h6); send(4'h7); send(4'h8);
    check("s6_new_word", 32'(bus.NIBBLES), 32'h8765);
    bus.NIBBLES_READY = 1'b1;
    tick();
    check("s6_drained", 32'(bus.NIBBLES_VALID), 32'd0);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      bus.NIB_VALID     = ($urandom % 4) != 0;
      bus.NIB_IN        = 4'($urandom);
      bus.FLUSH         = ($urandom % 20) == 0;
      bus.NIBBLES_READY = ($urandom % 3) != 0;
      tick();
    end
    bus.NIB_VALID     = 1'b0;
    bus.FLUSH         = 1'b1;
    bus.NIBBLES_READY = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);
    check("end_partial_empty", 32'(partial.size()), 32'd0);
    check("end_out_idle", 32'(bus.NIBBLES_VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
